// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: shared types and default widths for the unified memory arbiter.
package unified_mem_arbiter_pkg;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 16;
    typedef enum logic [1:0] {S_IDLE, S_IF, S_DM} owner_t;
endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, data and memory-side signals of the arbiter; slave is the arbiter's view.
interface unified_mem_arbiter_if import unified_mem_arbiter_pkg::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  if_req, if_gnt, if_rvalid;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  dm_rd, dm_wr, dm_gnt, dm_rvalid;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata, dm_rdata;
    logic                  stall_if, stall_dm, proto_err;
    logic                  mem_en, mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               stall_if, stall_dm, proto_err, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               stall_if, stall_dm, proto_err, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter_streak.sv
// arb_streak_counter: counts DM grants won while IF waits; full forces the next contended grant to IF.
module arb_streak_counter #(
    parameter int MAX_DM_STREAK = 4,
    parameter int STREAK_WIDTH  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    input  logic dm_gnt,
    output logic full
);
    logic [STREAK_WIDTH-1:0] streak;
    assign full = streak == STREAK_WIDTH'(MAX_DM_STREAK);
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            streak <= '0;
        else if (!if_req || if_gnt)
            streak <= '0;
        else if (dm_gnt && !full)
            streak <= streak + STREAK_WIDTH'(1);
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port SRAM between fetch and data ports with bounded DM priority.
// Define ARB_STATS_EN to add saturating conflict / fetch-stall counters.
module unified_mem_arbiter import unified_mem_arbiter_pkg::*; #(
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int MAX_DM_STREAK = 4,
    parameter int STREAK_WIDTH  = 4
) (
    input  logic clk,
    input  logic rst,
    unified_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0] stat_conflicts,
    output logic [15:0] stat_if_stall
`endif
);
    owner_t                state;
    logic                  dm_req, streak_full, dm_read_gnt;
    logic [DATA_WIDTH-1:0] if_hold, dm_hold;
    assign dm_req      = bus.dm_rd | bus.dm_wr;
    assign bus.dm_gnt  = dm_req & ~(bus.if_req & streak_full);
    assign bus.if_gnt  = bus.if_req & ~bus.dm_gnt;
    assign dm_read_gnt = bus.dm_gnt & ~bus.dm_wr;
    assign bus.stall_if = bus.if_req & ~bus.if_gnt;
    assign bus.stall_dm = dm_req & ~bus.dm_gnt;
    assign bus.mem_en    = bus.if_gnt | bus.dm_gnt;
    assign bus.mem_we    = bus.dm_gnt & bus.dm_wr;
    assign bus.mem_addr  = bus.dm_gnt ? bus.dm_addr : bus.if_gnt ? bus.if_addr : {ADDR_WIDTH{1'b0}};
    assign bus.mem_wdata = bus.dm_gnt ? bus.dm_wdata : {DATA_WIDTH{1'b0}};
    // read data passes straight through in the response cycle, then is held
    assign bus.if_rdata = (state == S_IF) ? bus.mem_rdata : if_hold;
    assign bus.dm_rdata = (state == S_DM) ? bus.mem_rdata : dm_hold;
    arb_streak_counter #(
        .MAX_DM_STREAK(MAX_DM_STREAK),
        .STREAK_WIDTH (STREAK_WIDTH)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .if_req(bus.if_req),
        .if_gnt(bus.if_gnt),
        .dm_gnt(bus.dm_gnt),
        .full  (streak_full)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state         <= S_IDLE;
            bus.if_rvalid <= 1'b0;
            bus.dm_rvalid <= 1'b0;
            bus.proto_err <= 1'b0;
            if_hold       <= '0;
            dm_hold       <= '0;
        end else begin
            state         <= bus.if_gnt ? S_IF : dm_read_gnt ? S_DM : S_IDLE;
            bus.if_rvalid <= bus.if_gnt;
            bus.dm_rvalid <= dm_read_gnt;
            bus.proto_err <= bus.proto_err | (bus.dm_rd & bus.dm_wr);
            if_hold       <= bus.if_rdata;
            dm_hold       <= bus.dm_rdata;
        end
`ifdef ARB_STATS_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            stat_conflicts <= '0;
            stat_if_stall  <= '0;
        end else begin
            if (bus.if_req && dm_req && stat_conflicts != 16'hFFFF)
                stat_conflicts <= stat_conflicts + 16'd1;
            if (bus.stall_if && stat_if_stall != 16'hFFFF)
                stat_if_stall <= stat_if_stall + 16'd1;
        end
`endif
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: table vectors, directed corner cases and random traffic against a behavioural model.
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;
    localparam int MAX = 4;

    typedef struct {
        logic       ir, rd, wr;
        logic [7:0] ia, da;
        logic [15:0] wd;
        logic       eig, edg, esi;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    unified_mem_arbiter_if bus ();
`ifdef ARB_STATS_EN
    logic [15:0] stat_conflicts, stat_if_stall;
`endif

    unified_mem_arbiter #(.MAX_DM_STREAK(MAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ARB_STATS_EN
        ,
        .stat_conflicts(stat_conflicts),
        .stat_if_stall (stat_if_stall)
`endif
    );

    function automatic logic [15:0] init_val(int a);
        return 16'(32'h1000 + a * 7);
    endfunction

    // SRAM macro: one-cycle read latency, write-first; unwritten words read their initial pattern
    bit [15:0]  sram [256];
    bit [255:0] wrote;
    always @(posedge clk)
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                sram[bus.mem_addr]  <= bus.mem_wdata;
                wrote[bus.mem_addr] <= 1'b1;
            end
            bus.mem_rdata <= bus.mem_we ? bus.mem_wdata :
                             wrote[bus.mem_addr] ? sram[bus.mem_addr] : init_val(int'(bus.mem_addr));
        end

    logic [15:0] ref_mem [256];
    int          m_streak, m_owner, m_conf, m_stall;
    logic [15:0] m_if_rd, m_dm_rd;
    logic        m_proto;
    int          n_vec = 0;
    int          n_err = 0;
    vec_t        tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_streak = 0;
        m_owner  = 0;
        m_conf   = 0;
        m_stall  = 0;
        m_if_rd  = '0;
        m_dm_rd  = '0;
        m_proto  = 1'b0;
    endtask

    task automatic drive_idle();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_rd    = 1'b0;
        bus.dm_wr    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
    endtask

    task automatic step(input logic ir, input logic [7:0] ia, input logic rd, input logic wr,
                        input logic [7:0] da, input logic [15:0] wd);
        logic dreq, dg, ig;
        @(negedge clk);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.dm_rd    = rd;
        bus.dm_wr    = wr;
        bus.dm_addr  = da;
        bus.dm_wdata = wd;
        #1;
        dreq = rd | wr;
        dg   = dreq && !(ir && m_streak == MAX);
        ig   = ir && !dg;
        chk("if_gnt",    bus.if_gnt,    ig);
        chk("dm_gnt",    bus.dm_gnt,    dg);
        chk("stall_if",  bus.stall_if,  ir && !ig);
        chk("stall_dm",  bus.stall_dm,  dreq && !dg);
        chk("mem_en",    bus.mem_en,    ig || dg);
        chk("mem_we",    bus.mem_we,    dg && wr);
        chk("mem_addr",  bus.mem_addr,  dg ? da : ig ? ia : 8'h00);
        chk("mem_wdata", bus.mem_wdata, dg ? wd : 16'h0000);
        chk("if_rvalid", bus.if_rvalid, m_owner == 1);
        chk("dm_rvalid", bus.dm_rvalid, m_owner == 2);
        chk("if_rdata",  bus.if_rdata,  m_if_rd);
        chk("dm_rdata",  bus.dm_rdata,  m_dm_rd);
        chk("proto_err", bus.proto_err, m_proto);
`ifdef ARB_STATS_EN
        chk("stat_conflicts", stat_conflicts, m_conf);
        chk("stat_if_stall",  stat_if_stall,  m_stall);
`endif
        if (rst) begin
            if (ir && dreq && m_conf < 65535) m_conf++;
            if (ir && !ig && m_stall < 65535) m_stall++;
            if (rd && wr) m_proto = 1'b1;
            if (!ir || ig) m_streak = 0;
            else if (dg && m_streak < MAX) m_streak++;
            if (dg && wr) begin
                ref_mem[da] = wd;
                m_owner = 0;
            end else if (dg) begin
                m_owner = 2;
                m_dm_rd = ref_mem[da];
            end else if (ig) begin
                m_owner = 1;
                m_if_rd = ref_mem[ia];
            end else
                m_owner = 0;
        end
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        model_reset();
        drive_idle();
        idle();
        idle();
        rst = 1'b1;

        // contention pattern, then single requesters
        for (int k = 0; k < 10; k++)
            tbl[k] = '{1'b1, 1'b1, 1'b0, 8'(8'h20 + k / 5), 8'(8'h40 + k), 16'h0,
                       (k == 4 || k == 9), !(k == 4 || k == 9), !(k == 4 || k == 9)};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 16'h0,    1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h80, 16'h5A5A, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 12; k++) begin
            step(tbl[k].ir, tbl[k].ia, tbl[k].rd, tbl[k].wr, tbl[k].da, tbl[k].wd);
            chk("tbl_if_gnt",   bus.if_gnt,   tbl[k].eig);
            chk("tbl_dm_gnt",   bus.dm_gnt,   tbl[k].edg);
            chk("tbl_stall_if", bus.stall_if, tbl[k].esi);
        end

        for (int a = 0; a < 4; a++) step(1'b1, 8'(a), 1'b0, 1'b0, 8'h00, 16'h0);
        idle();
        chk("fetch_rvalid", bus.if_rvalid, 1'b1);
        chk("fetch_rdata",  bus.if_rdata,  16'h1015);

        step(1'b0, 8'h00, 1'b0, 1'b1, 8'd12, 16'd7);
        step(1'b0, 8'h00, 1'b1, 1'b0, 8'd12, 16'd0);
        idle();
        chk("rd12_rvalid",   bus.dm_rvalid, 1'b1);
        chk("rd12_rdata",    bus.dm_rdata,  16'd7);
        chk("rd12_if_quiet", bus.if_rvalid, 1'b0);

        step(1'b0, 8'h00, 1'b1, 1'b1, 8'd5, 16'hABCD);
        idle();
        chk("both_no_rvalid", bus.dm_rvalid, 1'b0);
        chk("both_proto",     bus.proto_err, 1'b1);
        chk("both_mem5",      sram[5],       16'hABCD);
        idle();
        chk("proto_sticky",   bus.proto_err, 1'b1);

        // reset lands between an IF grant and its response
        step(1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 16'h0);
        #2;
        rst = 1'b0;
        drive_idle();
        model_reset();
        idle();
        chk("rst_if_rvalid", bus.if_rvalid, 1'b0);
        chk("rst_proto",     bus.proto_err, 1'b0);
        rst = 1'b1;
        idle();
        chk("post_rst_if_rvalid", bus.if_rvalid, 1'b0);

`ifdef ARB_STATS_EN
        for (int k = 0; k < 10; k++) step(1'b1, 8'h01, 1'b1, 1'b0, 8'h02, 16'h0);
        idle();
        chk("stats_conflicts", stat_conflicts, 16'd10);
        chk("stats_if_stall",  stat_if_stall,  16'd8);
`endif

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 15);
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)),
                 (r < 6) || (r == 15), (r >= 6 && r < 10) || (r == 15),
                 8'($urandom_range(0, 15)), 16'($urandom));
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
